// File: rtl/data_memory_init.sv
// ============================================================================
// Module   : data_memory_init
// Brief    : Word-organised data RAM with a post-reset init sweep and a sticky
//            illegal-access flag, serving a CPU data port.
// Revision : 1.0
// ============================================================================
`default_nettype none

module data_memory_init #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          DEPTH_WORDS = 256,
    parameter logic [31:0] INIT_VALUE  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_enable,
    input  logic [31:0] data_address,
    input  logic        data_write,
    input  logic        data_read,
    input  logic [31:0] data_writedata,
    output logic [31:0] data_readdata,
    output logic        init_done,
    output logic        bad_access
);

    localparam int          AW        = $clog2(DEPTH_WORDS);
    localparam logic [31:0] BYTE_SPAN = 32'(4 * DEPTH_WORDS);
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH_WORDS - 1);

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          bad_access_q, bad_access_d;

    logic [31:0]   mem_q [DEPTH_WORDS];
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [31:0]   mem_wdata;

    logic [31:0]   offset;
    logic [AW-1:0] idx;
    logic          in_range;
    logic          access;

    // Unsigned compare: addresses below the base wrap high and fall out of range.
    assign offset   = data_address - BASE_ADDR;
    assign in_range = offset < BYTE_SPAN;
    assign idx      = offset[AW+1:2];
    assign access   = data_read | data_write;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bad_access_d = bad_access_q;
        mem_we       = 1'b0;
        mem_waddr    = idx;
        mem_wdata    = data_writedata;

        if (clk_enable) begin
            if (state_q == ST_INIT) begin
                mem_we    = 1'b1;
                mem_waddr = cnt_q;
                mem_wdata = INIT_VALUE;
                cnt_d     = cnt_q + 1'b1;
                if (cnt_q == LAST_IDX) begin
                    state_d = ST_RUN;
                end
                if (access) begin
                    bad_access_d = 1'b1;
                end
            end else begin
                if (data_write && in_range) begin
                    mem_we = 1'b1;
                end
                if (access && !in_range) begin
                    bad_access_d = 1'b1;
                end
            end
            if (data_read && data_write) begin
                bad_access_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_INIT;
            cnt_q        <= '0;
            bad_access_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bad_access_q <= bad_access_d;
        end
    end

    // Storage is deliberately unreset; the sweep provides the known contents.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    always_comb begin
        data_readdata = 32'h0;
        if (data_read && (state_q == ST_RUN) && in_range) begin
            data_readdata = mem_q[idx];
        end
    end

    assign init_done  = (state_q == ST_RUN);
    assign bad_access = bad_access_q;

endmodule

`default_nettype wire

// File: tb/tb_data_memory_init.sv
// ============================================================================
// Module   : tb_data_memory_init
// Brief    : Directed self-checking bench for data_memory_init.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_data_memory_init;

    logic        clk;
    logic        reset;
    logic        clk_enable;
    logic [31:0] data_address;
    logic        data_write;
    logic        data_read;
    logic [31:0] data_writedata;
    logic [31:0] data_readdata;
    logic        init_done;
    logic        bad_access;

    int vecs = 0;
    int errs = 0;

    data_memory_init #(
        .BASE_ADDR  (32'h0000_0000),
        .DEPTH_WORDS(256),
        .INIT_VALUE (32'hDEAD_BEEF)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .clk_enable    (clk_enable),
        .data_address  (data_address),
        .data_write    (data_write),
        .data_read     (data_read),
        .data_writedata(data_writedata),
        .data_readdata (data_readdata),
        .init_done     (init_done),
        .bad_access    (bad_access)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        data_write     = 1'b0;
        data_read      = 1'b0;
        data_address   = 32'h0;
        data_writedata = 32'h0;
    endtask

    // Asserts reset mid-cycle, releases it just after the next rising edge.
    task automatic pulse_reset();
        reset = 1'b1;
        #2;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Enabled edges until init_done is seen, capped so the bench cannot hang.
    task automatic count_to_done(output int n);
        n = 0;
        while (!init_done && n < 400) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        idle();
        clk_enable = 1'b1;
        reset      = 1'b1;
        data_read  = 1'b1;
        data_address = 32'h0;
        #3;
        vecs++;
        if (init_done !== 1'b0) begin
            errs++; $display("FAIL reset_init_done got %b want 0", init_done);
        end
        vecs++;
        if (bad_access !== 1'b0) begin
            errs++; $display("FAIL reset_bad_access got %b want 0", bad_access);
        end
        vecs++;
        if (data_readdata !== 32'h0) begin
            errs++; $display("FAIL reset_readdata got %h want 00000000", data_readdata);
        end
        idle();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_sweep();
        int n;
        count_to_done(n);
        vecs++;
        if (n !== 256) begin
            errs++; $display("FAIL sweep_edges got %0d want 256", n);
        end
        data_read = 1'b1;
        data_address = 32'h0;
        #1;
        vecs++;
        if (data_readdata !== 32'hDEAD_BEEF) begin
            errs++; $display("FAIL sweep_word0 got %h want deadbeef", data_readdata);
        end
        data_address = 32'h3FC;
        #1;
        vecs++;
        if (data_readdata !== 32'hDEAD_BEEF) begin
            errs++; $display("FAIL sweep_word255 got %h want deadbeef", data_readdata);
        end
        tick();
        idle();
        vecs++;
        if (bad_access !== 1'b0) begin
            errs++; $display("FAIL sweep_bad got %b want 0", bad_access);
        end
    endtask

    task automatic test_write_read();
        data_write = 1'b1; data_address = 32'h8; data_writedata = 32'hFF00_1234;
        tick();
        data_address = 32'h10; data_writedata = 32'hAAAA_AAAA;
        tick();
        idle();
        data_read = 1'b1; data_address = 32'h8;
        #1;
        vecs++;
        if (data_readdata !== 32'hFF00_1234) begin
            errs++; $display("FAIL wr_rd_0x8 got %h want ff001234", data_readdata);
        end
        data_address = 32'hB;
        #1;
        vecs++;
        if (data_readdata !== 32'hFF00_1234) begin
            errs++; $display("FAIL wr_rd_0xB got %h want ff001234", data_readdata);
        end
        data_address = 32'h10;
        #1;
        vecs++;
        if (data_readdata !== 32'hAAAA_AAAA) begin
            errs++; $display("FAIL wr_rd_0x10 got %h want aaaaaaaa", data_readdata);
        end
        data_address = 32'hC;
        #1;
        vecs++;
        if (data_readdata !== 32'hDEAD_BEEF) begin
            errs++; $display("FAIL wr_rd_0xC got %h want deadbeef", data_readdata);
        end
        tick();
        idle();
        vecs++;
        if (bad_access !== 1'b0) begin
            errs++; $display("FAIL wr_rd_bad got %b want 0", bad_access);
        end
    endtask

    task automatic test_enable_hold();
        clk_enable = 1'b0;
        data_write = 1'b1; data_address = 32'h8; data_writedata = 32'h1234_5678;
        tick();
        data_address = 32'h400;
        tick();
        idle();
        clk_enable = 1'b1;
        data_read = 1'b1; data_address = 32'h8;
        #1;
        vecs++;
        if (data_readdata !== 32'hFF00_1234) begin
            errs++; $display("FAIL hold_mem got %h want ff001234", data_readdata);
        end
        data_read = 1'b0;
        #1;
        vecs++;
        if (bad_access !== 1'b0) begin
            errs++; $display("FAIL hold_bad got %b want 0", bad_access);
        end
    endtask

    task automatic test_back_to_back();
        data_read = 1'b1; data_write = 1'b1;
        data_address = 32'h10; data_writedata = 32'h5555_5555;
        #1;
        vecs++;
        if (data_readdata !== 32'hAAAA_AAAA) begin
            errs++; $display("FAIL rw_same_old got %h want aaaaaaaa", data_readdata);
        end
        tick();
        data_write = 1'b0;
        #1;
        vecs++;
        if (data_readdata !== 32'h5555_5555) begin
            errs++; $display("FAIL rw_same_new got %h want 55555555", data_readdata);
        end
        vecs++;
        if (bad_access !== 1'b1) begin
            errs++; $display("FAIL rw_same_bad got %b want 1", bad_access);
        end
        idle();
    endtask

    task automatic test_out_of_range();
        int n;
        pulse_reset();
        count_to_done(n);
        vecs++;
        if (n !== 256) begin
            errs++; $display("FAIL oor_sweep got %0d want 256", n);
        end
        vecs++;
        if (bad_access !== 1'b0) begin
            errs++; $display("FAIL oor_bad_pre got %b want 0", bad_access);
        end
        data_write = 1'b1; data_address = 32'h400; data_writedata = 32'h1;
        tick();
        idle();
        vecs++;
        if (bad_access !== 1'b1) begin
            errs++; $display("FAIL oor_write_bad got %b want 1", bad_access);
        end
        data_read = 1'b1; data_address = 32'h400;
        #1;
        vecs++;
        if (data_readdata !== 32'h0) begin
            errs++; $display("FAIL oor_read got %h want 00000000", data_readdata);
        end
        data_address = 32'hFFFF_FFFC;
        #1;
        vecs++;
        if (data_readdata !== 32'h0) begin
            errs++; $display("FAIL oor_wrap_read got %h want 00000000", data_readdata);
        end
        data_address = 32'h0;
        #1;
        vecs++;
        if (data_readdata !== 32'hDEAD_BEEF) begin
            errs++; $display("FAIL oor_alias_word0 got %h want deadbeef", data_readdata);
        end
        tick();
        data_read = 1'b0; data_write = 1'b1; data_address = 32'h4; data_writedata = 32'h7;
        tick();
        idle();
        vecs++;
        if (bad_access !== 1'b1) begin
            errs++; $display("FAIL oor_sticky got %b want 1", bad_access);
        end
    endtask

    task automatic test_reset_mid_sweep();
        int n;
        pulse_reset();
        repeat (100) tick();
        reset = 1'b1;
        #2;
        vecs++;
        if (bad_access !== 1'b0 || init_done !== 1'b0) begin
            errs++; $display("FAIL midrst_flags got bad=%b done=%b want 0 0", bad_access, init_done);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        data_read = 1'b1; data_address = 32'hC;
        #1;
        vecs++;
        if (data_readdata !== 32'h0) begin
            errs++; $display("FAIL midrst_init_read got %h want 00000000", data_readdata);
        end
        data_read = 1'b0; data_write = 1'b1; data_writedata = 32'h0000_1234;
        tick();
        idle();
        vecs++;
        if (bad_access !== 1'b1) begin
            errs++; $display("FAIL midrst_init_write_bad got %b want 1", bad_access);
        end
        count_to_done(n);
        vecs++;
        if (n + 1 !== 256) begin
            errs++; $display("FAIL midrst_sweep got %0d want 256", n + 1);
        end
        data_read = 1'b1; data_address = 32'hC;
        #1;
        vecs++;
        if (data_readdata !== 32'hDEAD_BEEF) begin
            errs++; $display("FAIL midrst_dropped got %h want deadbeef", data_readdata);
        end
        idle();
    endtask

    task automatic test_enable_sweep();
        int n;
        pulse_reset();
        repeat (50) tick();
        clk_enable = 1'b0;
        repeat (10) tick();
        vecs++;
        if (init_done !== 1'b0) begin
            errs++; $display("FAIL ensweep_frozen got %b want 0", init_done);
        end
        clk_enable = 1'b1;
        count_to_done(n);
        vecs++;
        if (n + 60 !== 266) begin
            errs++; $display("FAIL ensweep_total got %0d want 266", n + 60);
        end
        vecs++;
        if (bad_access !== 1'b0) begin
            errs++; $display("FAIL ensweep_bad got %b want 0", bad_access);
        end
    endtask

    initial begin
        test_reset();
        test_sweep();
        test_write_read();
        test_enable_hold();
        test_back_to_back();
        test_out_of_range();
        test_reset_mid_sweep();
        test_enable_sweep();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

`default_nettype wire
